// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status encodings,
// E pipeline register layout and bubble defaults.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register IDs with special meaning
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    // One-hot status encodings
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    // Bubble field defaults
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [3:0] BUBBLE_STAT  = STAT_AOK;

    // Where an operand value came from; anything other than FWD_VALP or
    // FWD_REG is a forwarded value.
    typedef enum logic [2:0] {
        FWD_VALP,
        FWD_E_VALE,
        FWD_M_VALM,
        FWD_M_VALE,
        FWD_W_VALM,
        FWD_W_VALE,
        FWD_REG
    } fwd_sel_t;

    // Contents of the E pipeline register
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    // A nop carrying no register IDs, injected on reset and on stalls/squashes
    function automatic e_reg_t bubble_e();
        e_reg_t b;
        b.stat  = BUBBLE_STAT;
        b.icode = BUBBLE_ICODE;
        b.ifun  = BUBBLE_IFUN;
        b.valC  = '0;
        b.valA  = '0;
        b.valB  = '0;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.srcA  = RNONE;
        b.srcB  = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64-bit, two asynchronous read ports, two
// synchronous write ports. When both write ports hit the same register the
// M port wins. Register ID RNONE reads as zero and is never written.
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_srcA,
    input  logic [3:0]  i_srcB,
    output logic [63:0] o_valA,
    output logic [63:0] o_valB,
    input  logic [3:0]  i_dstE,
    input  logic [63:0] i_valE,
    input  logic [3:0]  i_dstM,
    input  logic [63:0] i_valM
);

    logic [63:0] r_regs [0:14];

    // Reset loads %rsp with RSP_INIT and clears the rest; the M write is
    // issued last so it overrides the E write to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= (i == int'(RSP)) ? RSP_INIT : 64'd0;
            end
        end else begin
            if (i_dstE != RNONE) begin
                r_regs[i_dstE] <= i_valE;
            end
            if (i_dstM != RNONE) begin
                r_regs[i_dstM] <= i_valM;
            end
        end
    end

    assign o_valA = (i_srcA == RNONE) ? 64'd0 : r_regs[i_srcA];
    assign o_valB = (i_srcB == RNONE) ? 64'd0 : r_regs[i_srcB];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode / write-back stage: register ID selection, register file
// access, E/M/W forwarding and the E pipeline register.
// Optional feature macro DECODE_PERF_CNT_EN adds saturating performance
// counters for bubbles and forwarded operands.
module decode_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_fwd_a,
    output logic [31:0] perf_fwd_b
`endif
);

    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_rfA;
    logic [63:0] w_rfB;
    logic [63:0] w_valA;
    logic [63:0] w_valB;
    fwd_sel_t    w_selA;
    fwd_sel_t    w_selB;
    e_reg_t      r_e;

    y86_regfile #(
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_srcA (d_srcA),
        .i_srcB (d_srcB),
        .o_valA (w_rfA),
        .o_valB (w_rfB),
        .i_dstE (W_dstE),
        .i_valE (W_valE),
        .i_dstM (W_dstM),
        .i_valM (W_valM)
    );

    // Pick source and destination register IDs from the instruction code;
    // cmov keeps dstE=rB and leaves squashing to execute.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin d_srcA = D_rA; w_dstE = D_rB; end
            I_IRMOVQ: begin w_dstE = D_rB; end
            I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
            I_MRMOVQ: begin d_srcB = D_rB; w_dstM = D_rA; end
            I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; w_dstE = D_rB; end
            I_CALL:   begin d_srcB = RSP;  w_dstE = RSP; end
            I_RET:    begin d_srcA = RSP;  d_srcB = RSP; w_dstE = RSP; end
            I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; w_dstE = RSP; end
            I_POPQ:   begin d_srcA = RSP;  d_srcB = RSP; w_dstE = RSP; w_dstM = D_rA; end
            default:  ;
        endcase
    end

    // Operand A source priority: valP for call/jxx, then youngest stage
    // first; an RNONE source never matches a destination.
    always_comb begin
        w_selA = FWD_REG;
        if (D_icode == I_CALL || D_icode == I_JXX)           w_selA = FWD_VALP;
        else if (d_srcA != RNONE && d_srcA == e_dstE)        w_selA = FWD_E_VALE;
        else if (d_srcA != RNONE && d_srcA == M_dstM)        w_selA = FWD_M_VALM;
        else if (d_srcA != RNONE && d_srcA == M_dstE)        w_selA = FWD_M_VALE;
        else if (d_srcA != RNONE && d_srcA == W_dstM)        w_selA = FWD_W_VALM;
        else if (d_srcA != RNONE && d_srcA == W_dstE)        w_selA = FWD_W_VALE;
    end

    // Operand B uses the same stage priority without the valP shortcut.
    always_comb begin
        w_selB = FWD_REG;
        if (d_srcB != RNONE && d_srcB == e_dstE)             w_selB = FWD_E_VALE;
        else if (d_srcB != RNONE && d_srcB == M_dstM)        w_selB = FWD_M_VALM;
        else if (d_srcB != RNONE && d_srcB == M_dstE)        w_selB = FWD_M_VALE;
        else if (d_srcB != RNONE && d_srcB == W_dstM)        w_selB = FWD_W_VALM;
        else if (d_srcB != RNONE && d_srcB == W_dstE)        w_selB = FWD_W_VALE;
    end

    // Steer the selected sources onto the operand buses.
    always_comb begin
        w_valA = w_rfA;
        case (w_selA)
            FWD_VALP:   w_valA = D_valP;
            FWD_E_VALE: w_valA = e_valE;
            FWD_M_VALM: w_valA = m_valM;
            FWD_M_VALE: w_valA = M_valE;
            FWD_W_VALM: w_valA = W_valM;
            FWD_W_VALE: w_valA = W_valE;
            default:    w_valA = w_rfA;
        endcase
        w_valB = w_rfB;
        case (w_selB)
            FWD_E_VALE: w_valB = e_valE;
            FWD_M_VALM: w_valB = m_valM;
            FWD_M_VALE: w_valB = M_valE;
            FWD_W_VALM: w_valB = W_valM;
            FWD_W_VALE: w_valB = W_valE;
            default:    w_valB = w_rfB;
        endcase
    end

    // E pipeline register: reset beats bubble, bubble beats a normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e <= bubble_e();
        end else if (E_bubble) begin
            r_e <= bubble_e();
        end else begin
            r_e.stat  <= D_stat;
            r_e.icode <= D_icode;
            r_e.ifun  <= D_ifun;
            r_e.valC  <= D_valC;
            r_e.valA  <= w_valA;
            r_e.valB  <= w_valB;
            r_e.dstE  <= w_dstE;
            r_e.dstM  <= w_dstM;
            r_e.srcA  <= d_srcA;
            r_e.srcB  <= d_srcB;
        end
    end

    assign E_stat  = r_e.stat;
    assign E_icode = r_e.icode;
    assign E_ifun  = r_e.ifun;
    assign E_valC  = r_e.valC;
    assign E_valA  = r_e.valA;
    assign E_valB  = r_e.valB;
    assign E_dstE  = r_e.dstE;
    assign E_dstM  = r_e.dstM;
    assign E_srcA  = r_e.srcA;
    assign E_srcB  = r_e.srcB;

`ifdef DECODE_PERF_CNT_EN
    logic        w_fwdA;
    logic        w_fwdB;
    logic [31:0] r_perfBubbles;
    logic [31:0] r_perfFwdA;
    logic [31:0] r_perfFwdB;

    assign w_fwdA = (w_selA != FWD_VALP) && (w_selA != FWD_REG);
    assign w_fwdB = (w_selB != FWD_REG);

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfBubbles <= '0;
            r_perfFwdA    <= '0;
            r_perfFwdB    <= '0;
        end else begin
            if (E_bubble && r_perfBubbles != '1) r_perfBubbles <= r_perfBubbles + 32'd1;
            if (w_fwdA && r_perfFwdA != '1)      r_perfFwdA    <= r_perfFwdA + 32'd1;
            if (w_fwdB && r_perfFwdB != '1)      r_perfFwdB    <= r_perfFwdB + 32'd1;
        end
    end

    assign perf_bubbles = r_perfBubbles;
    assign perf_fwd_a   = r_perfFwdA;
    assign perf_fwd_b   = r_perfFwdB;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset state, register ID
// selection, forwarding priority, bubble/reset precedence, write-port
// conflicts and (with DECODE_PERF_CNT_EN) the performance counters.
module tb_decode_stage;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_fwd_a, perf_fwd_b;
`endif

    int errors = 0;
    int checks = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    decode_stage #(.RSP_INIT(64'd200)) dut (
        .clk      (clk),
        .rst      (rst),
        .D_stat   (D_stat),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP),
        .E_bubble (E_bubble),
        .e_dstE   (e_dstE),
        .e_valE   (e_valE),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .M_valE   (M_valE),
        .m_valM   (m_valM),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .E_srcA   (E_srcA),
        .E_srcB   (E_srcB)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_bubbles (perf_bubbles),
        .perf_fwd_a   (perf_fwd_a),
        .perf_fwd_b   (perf_fwd_b)
`endif
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check that every E field holds the bubble value
    task automatic checkBubble(input string tag);
        checkOutput({tag, "_stat"},  E_stat,  64'h8);
        checkOutput({tag, "_icode"}, E_icode, 64'h1);
        checkOutput({tag, "_ifun"},  E_ifun,  64'h0);
        checkOutput({tag, "_valC"},  E_valC,  64'h0);
        checkOutput({tag, "_valA"},  E_valA,  64'h0);
        checkOutput({tag, "_valB"},  E_valB,  64'h0);
        checkOutput({tag, "_dstE"},  E_dstE,  64'hF);
        checkOutput({tag, "_dstM"},  E_dstM,  64'hF);
        checkOutput({tag, "_srcA"},  E_srcA,  64'hF);
        checkOutput({tag, "_srcB"},  E_srcB,  64'hF);
    endtask

    // Quiet pipeline: nop in D, no downstream destinations
    task automatic setIdle();
        D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 4'h0;
        D_rA = 4'hF; D_rB = 4'hF; D_valC = 64'd0; D_valP = 64'd0;
        E_bubble = 1'b0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        setIdle();
        applyStimulus();
        applyStimulus();
        checkBubble("reset");
        checkOutput("reset_nop_srcA", d_srcA, 64'hF);

        // Register file after reset: addq %rax,%rsp reads reg0 and reg4
        rst = 1'b0;
        D_icode = 4'h6; D_rA = 4'h0; D_rB = 4'h4;
        #1;
        checkOutput("opq_srcA", d_srcA, 64'h0);
        checkOutput("opq_srcB", d_srcB, 64'h4);
        applyStimulus();
        checkOutput("rf_reg0", E_valA, 64'd0);
        checkOutput("rf_reg4", E_valB, 64'd200);
        checkOutput("opq_dstE", E_dstE, 64'h4);

        // irmovq $10,%rdx enters E
        setIdle();
        D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h2; D_valC = 64'd10;
        applyStimulus();
        checkOutput("irmovq_icode", E_icode, 64'h3);
        checkOutput("irmovq_dstE", E_dstE, 64'h2);
        checkOutput("irmovq_valC", E_valC, 64'd10);
        checkOutput("irmovq_srcA", E_srcA, 64'hF);

        // addq %rdx,%rax with rdx in M, rax in E, stale rdx in W
        setIdle();
        D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h0;
        e_dstE = 4'h0; e_valE = 64'd3;
        M_dstE = 4'h2; M_valE = 64'd10;
        W_dstE = 4'h2; W_valE = 64'd99;
        applyStimulus();
        checkOutput("fwd_addq_valA_M", E_valA, 64'd10);
        checkOutput("fwd_addq_valB_e", E_valB, 64'd3);
        checkOutput("fwd_addq_dstE", E_dstE, 64'h0);

        // rrmovq %rbx,%rcx: e_valE beats m_valM on a tie
        setIdle();
        D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h1;
        M_dstM = 4'h3; m_valM = 64'd7;
        e_dstE = 4'h3; e_valE = 64'd9;
        applyStimulus();
        checkOutput("tie_e_over_m", E_valA, 64'd9);
        checkOutput("tie_dstE", E_dstE, 64'h1);

        // m_valM beats M_valE
        e_dstE = 4'hF; M_dstE = 4'h3; M_valE = 64'd8;
        applyStimulus();
        checkOutput("tie_mvalM_over_MvalE", E_valA, 64'd7);

        // W_valM beats W_valE
        setIdle();
        D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h1;
        W_dstM = 4'h3; W_valM = 64'd11; W_dstE = 4'h3; W_valE = 64'd12;
        applyStimulus();
        checkOutput("tie_WvalM_over_WvalE", E_valA, 64'd11);

        // Bubble wins over a call in D
        setIdle();
        D_icode = 4'h8; D_valP = 64'd9; E_bubble = 1'b1;
        applyStimulus();
        checkOutput("bubble_icode", E_icode, 64'h1);
        checkOutput("bubble_dstE", E_dstE, 64'hF);

        // Reset together with bubble, live instruction and forwarding in flight
        setIdle();
        D_icode = 4'h6; D_rA = 4'h4; D_rB = 4'h4; D_valC = 64'h55;
        e_dstE = 4'h4; e_valE = 64'd77; E_bubble = 1'b1; rst = 1'b1;
        applyStimulus();
        checkBubble("rst_bubble");

        // Write-port conflict: both W ports target reg 3
        rst = 1'b0;
        setIdle();
        W_dstE = 4'h3; W_valE = 64'd5; W_dstM = 4'h3; W_valM = 64'd6;
        applyStimulus();
        setIdle();
        D_icode = 4'hA; D_rA = 4'h3;
        applyStimulus();
        checkOutput("wport_conflict_reg3", E_valA, 64'd6);
        checkOutput("pushq_valB_rsp", E_valB, 64'd200);
        checkOutput("pushq_dstE", E_dstE, 64'h4);

        // call with valP=9
        setIdle();
        D_icode = 4'h8; D_valP = 64'd9;
        applyStimulus();
        checkOutput("call_valA", E_valA, 64'd9);
        checkOutput("call_dstE", E_dstE, 64'h4);
        checkOutput("call_srcA", E_srcA, 64'hF);
        checkOutput("call_dstM", E_dstM, 64'hF);

        // popq %rbp
        setIdle();
        D_icode = 4'hB; D_rA = 4'h5;
        applyStimulus();
        checkOutput("popq_dstM", E_dstM, 64'h5);
        checkOutput("popq_srcA", E_srcA, 64'h4);
        checkOutput("popq_valA", E_valA, 64'd200);

        // Non-AOK status passes through
        setIdle();
        D_stat = 4'b0100; D_icode = 4'h0;
        applyStimulus();
        checkOutput("hlt_stat", E_stat, 64'h4);
        checkOutput("hlt_dstE", E_dstE, 64'hF);

        // Unknown icode: IDs all RNONE, rest passed through
        setIdle();
        D_icode = 4'hC; D_ifun = 4'h2; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'h55;
        applyStimulus();
        checkOutput("unk_icode", E_icode, 64'hC);
        checkOutput("unk_ifun", E_ifun, 64'h2);
        checkOutput("unk_valC", E_valC, 64'h55);
        checkOutput("unk_dstE", E_dstE, 64'hF);
        checkOutput("unk_srcB", E_srcB, 64'hF);

        // An RNONE source must not match an RNONE destination
        setIdle();
        e_dstE = 4'hF; e_valE = 64'd77;
        applyStimulus();
        checkOutput("rnone_no_match", E_valA, 64'd0);

`ifdef DECODE_PERF_CNT_EN
        // Counters: 3 bubbles, then 2 forwarded A operands
        setIdle();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        E_bubble = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        setIdle();
        D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h1;
        e_dstE = 4'h2; e_valE = 64'd1;
        applyStimulus();
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("perf_bubbles", perf_bubbles, 64'd3);
        checkOutput("perf_fwd_a", perf_fwd_a, 64'd2);
        checkOutput("perf_fwd_b", perf_fwd_b, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
